simd_sat_stage: RTL
===================

# simd_sat_stage

Registered saturation and output stage downstream of the SIMD lane-control/adder slices. Accepts a raw 32-bit partitioned sum with per-slice sign and overflow, clamps overflowed lanes when saturation is enabled, and presents the result through a valid/ready interface with a 2-entry skid buffer. Also keeps sticky and counted saturation statistics for status readback.

## Interface
- `WIDTH_CNT`, 16: width of saturation-event counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_sum`  in  32  raw partitioned sum; slice i = bits [8i+7:8i].
- `in_sign`  in  4  operand-A sign bit of each slice's MSB.
- `in_overflow`  in  4  signed overflow out of each slice.
- `width`  in  2  lane mode: 00 = 4x8, 01 = 2x16, 10 = 1x32, 11 = treated as 00.
- `saturate`  in  1  clamp overflowed lanes when 1; wrap when 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  32  final lane results.
- `out_sat`  out  4  per-slice flag, set on every slice of a clamped lane.
- `sat_sticky`  out  1  set on any clamped lane since last clear.
- `sat_count`  out  WIDTH_CNT  clamped lanes accepted, saturating at all-ones.
- `clr_stats`  in  1  synchronous clear of `sat_sticky`/`sat_count`.

## Operation
- Lane top slices: 00 -> {0,1,2,3}; 01 -> {1,3}; 10 -> {3}. Only the top slice's `in_overflow` and `in_sign` are used; lower-slice flags are ignored.
- Lane clamps iff `saturate`=1 and top-slice overflow=1. Clamp value is lane max (0x7F.., sign=0) or lane min (0x80.., sign=1) across the full lane width.
- Non-clamped lanes pass `in_sum` bits unchanged. `out_sat` is all zero when `saturate`=0.
- Datapath: combinational clamp -> output register (`out_*`) plus one skid register. Transfer happens when valid && ready on the same edge.
- Skid: `in_ready` is registered, equal to !skid_full. If output reg holds data and `out_ready`=0 while input fires, the word goes to skid. When output drains, skid moves to output the same edge; a simultaneous new input lands in skid. No word is dropped or duplicated; order is preserved.
- Stats update on input acceptance (not output): `sat_count` += number of clamped lanes (0-4), saturating; `sat_sticky` |= any clamp.
- `clr_stats` with a same-cycle accept: the counter loads that word's increment, and sticky loads that word's any-clamp. Clear wins over the old value only.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_sat`=0, `in_ready`=1, skid empty, `sat_sticky`=0, `sat_count`=0.
- Latency: accept at edge N -> `out_valid`=1 with result after edge N (visible in cycle N+1), when the output reg is free.
- Throughput: 1 word/cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid fills and rises the cycle after it empties.
- `out_valid`/`out_result` stay stable while `out_valid` && !`out_ready`.
- `width`/`saturate` are sampled with `in_sum` at the accept edge. Mode changes between words need no bubble.
- Reset mid-stream: both entries are discarded immediately (async) and stats are cleared.
- Counter at max: it holds all-ones and does not wrap.

## Test plan
- 4x8, saturate=1, in_sum=0x80_7F_10_FF, overflow=4'b1001, sign=4'b0001 -> out_result=0x7F_7F_10_80, out_sat=4'b1001, sat_count=2.
- 2x16, saturate=1, overflow=4'b0010, sign[1]=1, in_sum=0x1234_7FFE -> out_result=0x1234_8000, out_sat=4'b0011. Lower-slice overflow bits are also varied and have no effect.
- 1x32, saturate=0, overflow=4'b1000 -> out_result=in_sum, out_sat=0, sat_count unchanged.
- Backpressure: 3 back-to-back words with out_ready=0 -> the first two are held (output + skid), and in_ready=0 from the cycle after the second. Releasing out_ready -> words emerge in order with no loss.
- Counter: preload near max via 4x8 all-overflow words -> sat_count sticks at 0xFFFF. clr_stats with a simultaneous 2-lane clamp -> sat_count=2, sat_sticky=1.
- Assert rst while output and skid are full -> out_valid=0, in_ready=1, and stats are 0 before the next edge.

Source files
------------

// File: rtl/simd_sat_stage.sv
// Saturation/output stage for the SIMD adder: clamps overflowed lanes, registers the result
// behind a valid/ready port with a 2-entry skid buffer, and keeps saturation statistics.
module simd_sat_stage #(
   parameter int WIDTH_CNT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_sum,
   input  logic [3:0]           in_sign,
   input  logic [3:0]           in_overflow,
   input  logic [1:0]           width,
   input  logic                 saturate,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_result,
   output logic [3:0]           out_sat,
   output logic                 sat_sticky,
   output logic [WIDTH_CNT-1:0] sat_count,
   input  logic                 clr_stats
);

   logic [1:0]           w_mode;
   logic [1:0]           w_top [4];
   logic [3:0]           w_is_top;
   logic [3:0]           w_sat;
   logic [31:0]          w_result;
   logic [2:0]           w_lane_cnt;
   logic                 w_any;
   logic                 w_accept;
   logic                 w_out_free;
   logic [WIDTH_CNT:0]   w_cnt_sum;
   logic [WIDTH_CNT-1:0] w_cnt_inc;

   logic                 r_out_valid;
   logic [31:0]          r_out_result;
   logic [3:0]           r_out_sat;
   logic                 r_skid_valid;
   logic [31:0]          r_skid_result;
   logic [3:0]           r_skid_sat;
   logic                 r_sticky;
   logic [WIDTH_CNT-1:0] r_cnt;

   assign w_mode = (width == 2'b11) ? 2'b00 : width;

   // Every slice looks at the flags of its lane's top slice; lower slices fill with 00/FF.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slice
         assign w_top[gi] = (w_mode == 2'b10) ? 2'd3 :
                            (w_mode == 2'b01) ? (2'(gi) | 2'd1) : 2'(gi);
         assign w_is_top[gi] = (w_top[gi] == 2'(gi));
         assign w_sat[gi]    = saturate & in_overflow[w_top[gi]];
         assign w_result[8*gi +: 8] =
            !w_sat[gi]              ? in_sum[8*gi +: 8] :
            w_is_top[gi]            ? (in_sign[w_top[gi]] ? 8'h80 : 8'h7F) :
                                      (in_sign[w_top[gi]] ? 8'h00 : 8'hFF);
      end
   endgenerate

   always_comb begin
      w_lane_cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         w_lane_cnt = w_lane_cnt + {2'b00, w_sat[i] & w_is_top[i]};
      end
   end

   assign w_any      = |w_sat;
   assign w_accept   = in_valid & in_ready;
   assign w_out_free = ~r_out_valid | out_ready;
   assign w_cnt_inc  = {{(WIDTH_CNT-3){1'b0}}, w_lane_cnt};
   assign w_cnt_sum  = {1'b0, r_cnt} + {1'b0, w_cnt_inc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'd0;
         r_out_sat     <= 4'd0;
         r_skid_valid  <= 1'b0;
         r_skid_result <= 32'd0;
         r_skid_sat    <= 4'd0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_result <= r_skid_result;
            r_out_sat    <= r_skid_sat;
            r_skid_valid <= w_accept;
            if (w_accept) begin
               r_skid_result <= w_result;
               r_skid_sat    <= w_sat;
            end
         end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
               r_out_result <= w_result;
               r_out_sat    <= w_sat;
            end
         end
      end else if (w_accept) begin
         r_skid_valid  <= 1'b1;
         r_skid_result <= w_result;
         r_skid_sat    <= w_sat;
      end
   end

   // A clear replaces only the old value; the word accepted in the same cycle still counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= 1'b0;
         r_cnt    <= '0;
      end else if (clr_stats) begin
         r_sticky <= w_accept & w_any;
         r_cnt    <= w_accept ? w_cnt_inc : '0;
      end else if (w_accept) begin
         r_sticky <= r_sticky | w_any;
         r_cnt    <= w_cnt_sum[WIDTH_CNT] ? '1 : w_cnt_sum[WIDTH_CNT-1:0];
      end
   end

   assign in_ready   = ~r_skid_valid;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_sat    = r_out_sat;
   assign sat_sticky = r_sticky;
   assign sat_count  = r_cnt;

endmodule
